// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit owning HI/LO for the EX stage
module md_unit #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic        md_hiwb,
    input  logic        md_lowb,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dnd_q, dnd_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic signed [65:0] mul_a, mul_b, prod_full;
    logic [32:0] shifted, trial;

    always_comb begin
        start     = ex_valid && (md_func == 3'd3 || md_func == 3'd4) && (state_q == S_IDLE);
        a_neg     = md_sign & op_a[31];
        b_neg     = md_sign & op_b[31];
        a_mag     = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag     = b_neg ? (~op_b + 32'd1) : op_b;
        // 33x33 semantics: extend with the sign bit only in signed mode
        mul_a     = {{33{a_neg}}, a_neg, op_a};
        mul_b     = {{33{b_neg}}, b_neg, op_b};
        prod_full = mul_a * mul_b;
        // quo_q starts as the dividend magnitude and fills with quotient bits from the right
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dnd_d   = dnd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    case (md_func)
                        3'd1: hi_d = op_a;
                        3'd2: lo_d = op_a;
                        3'd3: begin
                            state_d = S_MUL;
                            cnt_d   = 6'(MUL_CYCLES - 1);
                            prod_d  = prod_full[63:0];
                        end
                        3'd4: begin
                            state_d = S_DIV;
                            cnt_d   = 6'd32;
                            quo_d   = a_mag;
                            rem_d   = 32'd0;
                            dvs_d   = b_mag;
                            dnd_d   = op_a;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dz_d    = (op_b == 32'd0);
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 6'd0) begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV: begin
                if (cnt_q != 6'd0) begin
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    if (dz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = dnd_q;
                    end else begin
                        lo_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
                        hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            prod_q  <= 64'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            dnd_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dnd_q   <= dnd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = start || (state_q != S_IDLE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_rdata = md_hiwb ? hi_q : (md_lowb ? lo_q : 32'd0);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized and directed checks of md_unit against an arithmetic model
module tb_md_unit;

    localparam int MULC = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  md_func = 3'd0;
    logic        md_sign = 1'b0;
    logic        md_hiwb = 1'b0;
    logic        md_lowb = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic [31:0] md_rdata, hi, lo;

    int vectors = 0;
    int errs = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    md_unit #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .md_func(md_func),
        .md_sign(md_sign), .md_hiwb(md_hiwb), .md_lowb(md_lowb),
        .op_a(op_a), .op_b(op_b), .busy(busy), .md_rdata(md_rdata),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [2:0] f, input logic s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (f == 3'd3) begin
            p  = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    // Issues one mult/div, scribbles on all inputs while busy, counts busy cycles.
    task automatic run_op(input string tag, input logic [2:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input bit junk);
        int n;
        logic [31:0] mh, ml;
        @(posedge clk); #1;
        ex_valid = 1'b1; md_func = f; md_sign = s; op_a = a; op_b = b;
        @(negedge clk);
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0; md_func = 3'd0; md_sign = ~s; op_a = $urandom; op_b = $urandom;
        n = 1;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            if (n == 3) chk({tag, "_hold_hi"}, hi, exp_hi);
            if (junk) begin
                ex_valid = 1'b1; md_func = 3'($urandom_range(1, 2)); op_a = $urandom;
            end
            @(posedge clk); #1;
            ex_valid = 1'b0; md_func = 3'd0;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), (f == 3'd3) ? 32'(MULC + 1) : 32'd34);
        model(f, s, a, b, mh, ml);
        exp_hi = mh;
        exp_lo = ml;
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic        rs;

        // reset, with a start presented on the reset edge
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; ex_valid = 1'b1; md_func = 3'd4; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0; md_func = 3'd0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_rdata", md_rdata, 32'd0);

        // directed products and quotients
        run_op("mult_neg1x2", 3'd3, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("multu_ffx2", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", hi, 32'h0000_0001);
        run_op("div_m7_2", 3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        run_op("divu_fff9_2", 3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf", 3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        run_op("divu_by0", 3'd4, 1'b0, 32'd1234, 32'd0, 1'b0);
        run_op("div_by0_s", 3'd4, 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);

        // mthi/mtlo and mfhi/mflo
        @(posedge clk); #1;
        ex_valid = 1'b1; md_func = 3'd1; op_a = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mthi_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        md_func = 3'd2; op_a = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("mtlo_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0; md_func = 3'd1; op_a = 32'h1111_1111; md_hiwb = 1'b1;
        @(negedge clk);
        chk("mfhi", md_rdata, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        md_func = 3'd0; md_hiwb = 1'b0; md_lowb = 1'b1;
        @(negedge clk);
        chk("mflo", md_rdata, 32'h5A5A_5A5A);
        chk("mthi_novalid", hi, 32'hA5A5_A5A5);
        md_lowb = 1'b0;
        exp_hi = 32'hA5A5_A5A5;
        exp_lo = 32'h5A5A_5A5A;

        // writes attempted while busy must be ignored, operand changes too
        run_op("mult_intrude", 3'd3, 1'b0, 32'd1000, 32'd77, 1'b1);
        run_op("div_intrude", 3'd4, 1'b1, 32'hFFFF_8000, 32'd300, 1'b1);

        // randomized operations
        for (int i = 0; i < 12; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            run_op("rand", rf, rs, ra, rb, 1'($urandom_range(0, 1)));
        end

        // reset during DIV cycle 10
        @(posedge clk); #1;
        ex_valid = 1'b1; md_func = 3'd4; md_sign = 1'b0; op_a = 32'd999; op_b = 32'd3;
        @(posedge clk); #1;
        ex_valid = 1'b0; md_func = 3'd0;
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_stays_lo", lo, 32'd0);
        run_op("mult_3x4", 3'd3, 1'b0, 32'd3, 32'd4, 1'b0);
        chk("mult_3x4_const", lo, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the EX stage, owning the HI/LO registers. It consumes the controller's EX-stage MD fields (function code, sign, HI/LO read selects) and the forwarded rs/rt operands. It produces the mfhi/mflo read data for the EX result mux and a `busy` indication that stall detection uses to hold later MD instructions in ID.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..31.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: the EX-stage instruction is real (not a bubble or flush).
- `md_func` in 3: 0 none, 1 mthi, 2 mtlo, 3 mult, 4 div; 5..7 treated as none.
- `md_sign` in 1: 1 selects signed mult/div.
- `md_hiwb` in 1: mfhi select.
- `md_lowb` in 1: mflo select.
- `op_a` in 32: rs value (multiplicand / dividend / mthi/mtlo data).
- `op_b` in 32: rt value (multiplier / divisor).
- `busy` out 1: an operation is in flight, or one is starting this cycle.
- `md_rdata` out 32: `hi` if `md_hiwb`, else `lo` if `md_lowb`, else 0.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- Start condition: `start = ex_valid && (md_func==3 || md_func==4) && state==IDLE`.
- States:
  - IDLE. On `start` with func 3, go to MUL; with func 4, go to DIV.
  - mthi/mtlo (func 1/2 with `ex_valid`) in IDLE writes HI/LO at the edge.
- MUL:
  - The 64-bit product is computed at the start edge and held in a pending register.
  - The counter loads `MUL_CYCLES-1` and decrements once per cycle.
  - When it reaches 0, {HI,LO} ← product at that edge and the state returns to IDLE.
  - Signed mode uses sign-extended 33×33 semantics; unsigned mode uses zero-extension.
- DIV:
  - Restoring division on the magnitudes, one quotient bit per cycle, 32 iteration cycles, then one fix-up cycle. Total 33 busy cycles.
  - Fix-up cycle writes LO ← quotient and HI ← remainder, then returns to IDLE.
  - Signed results: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
  - Divide by zero: same 33-cycle latency, then LO=0xFFFFFFFF and HI=op_a as captured.
- Operands, `md_sign` and the op kind are captured at the start edge. Later changes to the inputs have no effect on the result.
- Any `md_func≠0` while state≠IDLE is ignored, including mthi/mtlo. Stall detection guarantees this never happens; the assertion bench checks it.
- `md_rdata` always reflects the current HI/LO. During an operation it shows the old values, because stall detection holds mfhi/mflo while `busy`.
- There is no cancellation: interrupts, ExlSet and branch correction never abort an in-flight operation.

## Timing
- `busy = start || (state≠IDLE)`. It is combinational on `start` so that an MD instruction in ID can be stalled in the same cycle the prior MD instruction sits in EX.
- Start at edge E0:
  - mult: busy is high in the start cycle plus cycles 1..MUL_CYCLES. HI/LO are updated at edge E(MUL_CYCLES). busy=0 and the new values are visible in the following cycle.
  - div: busy is high in the start cycle plus cycles 1..33. HI/LO are updated at edge E33.
- mthi/mtlo: the value is visible on `hi`/`lo` in the cycle after the edge. There is no internal bypass.
- Reset (any cycle, including mid-operation):
  - state IDLE, counter 0, `hi`=`lo`=0, pending result discarded.
  - `busy`=0 unless `start` is asserted in the same cycle. Reset wins: no start is taken on a reset edge.
- `ex_valid`=0 suppresses `start` and mthi/mtlo writes.

## Test plan
- Signed vs unsigned multiply:
  - mult 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after 5 busy cycles.
  - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide:
  - div −7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy for exactly 34 cycles including the start cycle.
  - divu 0xFFFFFFF9/2 → LO=0x7FFFFFFC, HI=1.
- Corner divides:
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu 1234/0 → LO=0xFFFFFFFF, HI=1234.
- Write and read HI/LO: mthi 0xA5A5A5A5, then mtlo 0x5A5A5A5A, then mfhi/mflo → `md_rdata` reads 0xA5A5A5A5 then 0x5A5A5A5A; `busy` never asserted.
- Operation while busy: issue mtlo 0x1 mid-multiply → LO ends with the product, not 1. Change `op_a`/`op_b` mid-divide → result unchanged.
- Reset mid-operation: assert `reset` during DIV cycle 10 → next cycle busy=0, HI=LO=0. A new mult 3×4 then gives LO=12.
